ahblite_slave_resp_mux: RTL

- Return-path companion to the AHB-Lite address decoder.
- Samples the decoder's one-hot slot select at each accepted address phase and holds it for the data phase.
- Multiplexes HRDATA, HREADYOUT and HRESP from the selected slave back to the master.
- Contains the default slave, which gives the two-cycle AHB ERROR response for reserved, disabled or illegally decoded addresses.

---
 rtl/ahblite_slave_resp_mux.sv | 94 +++++++++
 1 files changed

// File: rtl/ahblite_slave_resp_mux.sv
// rtl/ahblite_slave_resp_mux.sv - AHB-Lite slave response mux with built-in default (error) slave
module ahblite_slave_resp_mux #(
    parameter logic [16:0] M_AHBSLOTENABLE = 17'h1FFFF
) (
    input  logic         HCLK,
    input  logic         HRESETN,
    input  logic [1:0]   HTRANS,
    input  logic [16:0]  ADDRDEC,
    input  logic         RESERVEDDEC,
    output logic [16:0]  HSEL_S,
    input  logic [16:0]  HREADYOUT_S,
    input  logic [16:0]  HRESP_S,
    input  logic [543:0] HRDATA_S,
    output logic         HREADY_M,
    output logic         HRESP_M,
    output logic [31:0]  HRDATA_M,
    output logic [16:0]  DATASEL
);

    typedef enum logic [1:0] {
        D_IDLE  = 2'd0,
        D_SLAVE = 2'd1,
        D_ERR1  = 2'd2,
        D_ERR2  = 2'd3
    } dstate_t;

    dstate_t     state;
    logic [16:0] en;
    logic        en_onehot;
    logic        trans_active;
    logic        slave_ready;
    logic        slave_resp;
    logic [31:0] slave_rdata;

    assign en           = ADDRDEC & M_AHBSLOTENABLE;
    assign en_onehot    = (en != 17'd0) && ((en & (en - 17'd1)) == 17'd0);
    assign trans_active = (HTRANS == 2'b10) || (HTRANS == 2'b11);
    assign HSEL_S       = en;

    // AND-OR mux: a slave's signals are masked out unless its DATASEL bit is set
    always_comb begin
        slave_ready = 1'b0;
        slave_resp  = 1'b0;
        slave_rdata = 32'd0;
        for (int i = 0; i < 17; i++) begin
            slave_ready = slave_ready | (HREADYOUT_S[i] & DATASEL[i]);
            slave_resp  = slave_resp  | (HRESP_S[i] & DATASEL[i]);
            slave_rdata = slave_rdata | (HRDATA_S[32*i +: 32] & {32{DATASEL[i]}});
        end
    end

    always_comb begin
        HREADY_M = 1'b1;
        HRESP_M  = 1'b0;
        HRDATA_M = 32'd0;
        case (state)
            D_SLAVE: begin
                HREADY_M = slave_ready;
                HRESP_M  = slave_resp;
                HRDATA_M = slave_rdata;
            end
            D_ERR1: begin
                HREADY_M = 1'b0;
                HRESP_M  = 1'b1;
            end
            D_ERR2: begin
                HREADY_M = 1'b1;
                HRESP_M  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) begin
            state   <= D_IDLE;
            DATASEL <= 17'd0;
        end else if (state == D_ERR1) begin
            state <= D_ERR2;
        end else if (HREADY_M) begin
            if (!trans_active) begin
                state   <= D_IDLE;
                DATASEL <= 17'd0;
            end else if (en_onehot && !RESERVEDDEC) begin
                state   <= D_SLAVE;
                DATASEL <= en;
            end else begin
                state   <= D_ERR1;
                DATASEL <= 17'd0;
            end
        end
    end

endmodule
